// File: rtl/melody_sequencer_if.sv
// ---------------------------------------------------------------------------
// melody_sequencer_if
//   Bundles the control, table-load and tone-path signals of the melody
//   sequencer so the host side and the sequencer share one connection.
//
//   master modport (host / config logic + fs clkgen):
//     fs_tick, wr_en, wr_addr, wr_pitch, wr_dur, seq_len, loop_en, start, stop
//   slave modport (melody_sequencer):
//     busy, pitch_maxval, tone_on, note_start, note_idx, done
// ---------------------------------------------------------------------------
interface melody_sequencer_if #(
  parameter int ADDR_W  = 5,
  parameter int PITCH_W = 5,
  parameter int DUR_W   = 13
) ();

  logic               fs_tick;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [PITCH_W-1:0] wr_pitch;
  logic [DUR_W-1:0]   wr_dur;
  logic [ADDR_W:0]    seq_len;
  logic               loop_en;
  logic               start;
  logic               stop;

  logic               busy;
  logic [PITCH_W-1:0] pitch_maxval;
  logic               tone_on;
  logic               note_start;
  logic [ADDR_W-1:0]  note_idx;
  logic               done;

  modport master (
    output fs_tick, wr_en, wr_addr, wr_pitch, wr_dur, seq_len, loop_en, start, stop,
    input  busy, pitch_maxval, tone_on, note_start, note_idx, done
  );

  modport slave (
    input  fs_tick, wr_en, wr_addr, wr_pitch, wr_dur, seq_len, loop_en, start, stop,
    output busy, pitch_maxval, tone_on, note_start, note_idx, done
  );

endinterface

// File: rtl/melody_sequencer.sv
// ---------------------------------------------------------------------------
// melody_sequencer
//   Plays a loadable melody table (pitch code + duration per entry) into the
//   sine clkgen / DAC tone path. Durations are counted in fs samples; every
//   note change pulses note_start so the clkgen restarts its phase cleanly.
//
//   Ports:
//     clk    - system clock
//     reset  - asynchronous reset, active low
//     bus    - melody_sequencer_if.slave
//              in : fs_tick, wr_en/wr_addr/wr_pitch/wr_dur (table load, only
//                   while idle), seq_len, loop_en, start, stop
//              out: busy, pitch_maxval, tone_on, note_start, note_idx, done
//
//   Optional feature macro: ARTIC_GAP_EN
//     When defined, every note is followed by GAP_SAMPLES silent fs ticks
//     before the next entry is fetched (also before done on the last note).
// ---------------------------------------------------------------------------
module melody_sequencer #(
  parameter int ADDR_W      = 5,
  parameter int PITCH_W     = 5,
  parameter int DUR_W       = 13,
  parameter int GAP_SAMPLES = 200
) (
  input  logic              clk,
  input  logic              reset,
  melody_sequencer_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] PLAY  = 2'd2;
`ifdef ARTIC_GAP_EN
  localparam logic [1:0] GAP   = 2'd3;
  localparam int GAP_W = $clog2(GAP_SAMPLES + 1);
`endif

  if (GAP_SAMPLES < 1) begin : gBadGap
    $error("GAP_SAMPLES must be at least 1");
  end

  logic [1:0]               state_q, state_d;
  logic [ADDR_W-1:0]        idx_q, idx_d;
  logic [ADDR_W:0]          len_q, len_d;
  logic [DUR_W-1:0]         cnt_q, cnt_d;
  logic                     note_start_q, note_start_d;
  logic                     done_q, done_d;
`ifdef ARTIC_GAP_EN
  logic [GAP_W-1:0]         gap_cnt_q, gap_cnt_d;
`endif

  logic [PITCH_W+DUR_W-1:0] mem [DEPTH];
  logic [PITCH_W+DUR_W-1:0] rd_q;

  logic                     busy;
  logic [PITCH_W-1:0]       ent_pitch;
  logic [DUR_W-1:0]         ent_dur;
  logic [DUR_W-1:0]         last_cnt;
  logic                     is_last;
  logic                     len_ok;
  logic                     advance;

  assign busy      = (state_q != IDLE);
  assign ent_pitch = rd_q[PITCH_W+DUR_W-1:DUR_W];
  assign ent_dur   = rd_q[DUR_W-1:0];
  // A zero duration behaves like a one-tick note.
  assign last_cnt  = (ent_dur == '0) ? '0 : ent_dur - DUR_W'(1);
  assign is_last   = ({1'b0, idx_q} == len_q - (ADDR_W+1)'(1));
  assign len_ok    = (bus.seq_len != '0) && (bus.seq_len <= (ADDR_W+1)'(DEPTH));

  // Melody table: writes are only honoured while idle so a playing sequence
  // never sees its data change. The read is issued in FETCH and the word is
  // held for the whole note because idx cannot change until the note ends.
  always_ff @(posedge clk) begin
    if (bus.wr_en && !busy) begin
      mem[bus.wr_addr] <= {bus.wr_pitch, bus.wr_dur};
    end
    if (state_q == FETCH) begin
      rd_q <= mem[idx_q];
    end
  end

  // Next-state logic. Note end (or gap end) raises 'advance', which either
  // moves to the next entry, wraps to entry 0 when looping, or finishes.
  // A stop request overrides everything in any busy state.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    note_start_d = 1'b0;
    done_d       = 1'b0;
    advance      = 1'b0;
`ifdef ARTIC_GAP_EN
    gap_cnt_d    = gap_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop && len_ok) begin
          len_d   = bus.seq_len;
          idx_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d      = PLAY;
        note_start_d = 1'b1;
        cnt_d        = '0;
      end
      PLAY: begin
        if (bus.fs_tick) begin
          if (cnt_q == last_cnt) begin
`ifdef ARTIC_GAP_EN
            state_d   = GAP;
            gap_cnt_d = '0;
`else
            advance   = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + DUR_W'(1);
          end
        end
      end
`ifdef ARTIC_GAP_EN
      GAP: begin
        if (bus.fs_tick) begin
          if (gap_cnt_q == GAP_W'(GAP_SAMPLES - 1)) begin
            advance = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (!is_last) begin
        idx_d   = idx_q + ADDR_W'(1);
        state_d = FETCH;
      end else if (bus.loop_en) begin
        idx_d   = '0;
        state_d = FETCH;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end

    if (busy && bus.stop) begin
      state_d      = IDLE;
      idx_d        = idx_q;
      note_start_d = 1'b0;
      done_d       = 1'b0;
    end
  end

  // State registers; the table itself is deliberately left out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      note_start_q <= 1'b0;
      done_q       <= 1'b0;
`ifdef ARTIC_GAP_EN
      gap_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      note_start_q <= note_start_d;
      done_q       <= done_d;
`ifdef ARTIC_GAP_EN
      gap_cnt_q    <= gap_cnt_d;
`endif
    end
  end

  // The tone path only sounds in PLAY, so FETCH, GAP and IDLE are silent and
  // an asynchronous reset silences it immediately.
  assign bus.busy         = busy;
  assign bus.pitch_maxval = (state_q == PLAY) ? ent_pitch : '0;
  assign bus.tone_on      = (state_q == PLAY) && (ent_pitch != '0);
  assign bus.note_start   = note_start_q;
  assign bus.note_idx     = idx_q;
  assign bus.done         = done_q;

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Note scheduler that drives the sine/DAC tone path from a loadable melody table.
- The table holds a pitch code and a duration per entry. The table replaces the hard-coded note arrays.
- Counts note durations in fs samples and presents the current clkgen maxval to the sine clock generator.
- Pulses a resync strobe on every note change, so clkgen restarts cleanly when maxval changes. Sits between the host/config logic and the clkgen/sine/dac chain.

Parameters:
- ADDR_W, 5, table address width; DEPTH = 2**ADDR_W entries.
- PITCH_W, 5, width of pitch code (the clkgen maxval); code 0 = rest.
- DUR_W, 13, duration width in fs samples.
- GAP_SAMPLES, 200, silent fs samples between notes (only with ARTIC_GAP_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-low.
- fs_tick  in  1  one-cycle sample strobe (the fs clkgen output).
- wr_en  in  1  table write strobe; honoured only while busy=0.
- wr_addr  in  ADDR_W  table write address.
- wr_pitch  in  PITCH_W  pitch code to write.
- wr_dur  in  DUR_W  duration to write, in samples.
- seq_len  in  ADDR_W+1  number of entries to play, 1..DEPTH; sampled on start.
- loop_en  in  1  restart at entry 0 after the last entry; sampled continuously.
- start  in  1  one-cycle play request.
- stop  in  1  one-cycle abort request.
- busy  out  1  state != IDLE.
- pitch_maxval  out  PITCH_W  maxval for sine clkgen; 0 while not sounding.
- tone_on  out  1  high when a non-rest note is sounding; gates DAC t_on.
- note_start  out  1  one-cycle pulse on entry to each PLAY; resets clkgen phase.
- note_idx  out  ADDR_W  index of the current entry.
- done  out  1  one-cycle pulse when a non-looping sequence ends normally.

Behaviour:
- Reset (reset=0, async): state=IDLE, busy=0, pitch_maxval=0, tone_on=0, note_start=0, note_idx=0, done=0, duration counter=0, latched length=0. Table contents are not reset.
- Table: DEPTH x (PITCH_W+DUR_W) with synchronous read, one-cycle latency. A write occurs on clk when wr_en=1 and busy=0; writes while busy are dropped.
- IDLE state:
  - start=1, stop=0, seq_len in 1..DEPTH: latch len=seq_len, idx=0, go to FETCH.
  - seq_len=0 or seq_len>DEPTH: start is ignored.
  - start and stop in the same cycle: stop wins, stay IDLE.
- FETCH state (1 cycle): issue read of table[idx], go to PLAY.
- PLAY state:
  - On entry cycle: pitch_maxval=entry pitch, tone_on=(pitch!=0), note_start=1 for exactly that cycle, duration counter cleared.
  - Each fs_tick increments the counter.
  - On the fs_tick where counter==dur-1: note ends. dur=0 is treated as 1.
  - Note end: go to GAP if ARTIC_GAP_EN is defined, else go to ADVANCE.
- ADVANCE (combinational decision at note end):
  - idx<len-1: idx+1, go to FETCH.
  - idx==len-1 and loop_en=1: idx=0, go to FETCH.
  - idx==len-1 and loop_en=0: go to IDLE, pulse done for 1 cycle, pitch_maxval=0, tone_on=0.
- stop=1 in any non-IDLE state: go to IDLE on the next edge with pitch_maxval=0, tone_on=0, note_idx held, done not pulsed.
- start while busy: ignored.
- An fs_tick arriving in the FETCH cycle is not counted. Duration is measured from the first fs_tick after the PLAY entry.
- Counter is DUR_W bits and cannot overflow, since the compare happens at dur-1.
- note_idx mirrors idx, registered.

Optional Feature:
- Macro: ARTIC_GAP_EN.
- Defined:
  - After each note end, a GAP state holds pitch_maxval=0 and tone_on=0 for GAP_SAMPLES fs_ticks, then performs ADVANCE.
  - A separate gap counter is used.
  - On the last non-looping note, the gap is also played before done.
  - stop during GAP goes to IDLE.
- Undefined: no GAP state; the note end goes straight to ADVANCE and the next note_start follows 2 clk later.

Test Plan:
- Reset mid-PLAY: assert reset=0 asynchronously. All outputs go to their reset values without waiting for a clk edge; after release, busy=0.
- Basic sequence: load {(18,4),(13,2),(0,3)}, seq_len=3, loop_en=0, start, fs_tick every 10 clk.
  - pitch_maxval shows 18 for 4 ticks, then 13 for 2 ticks, then 0 with tone_on=0 for 3 ticks.
  - 3 note_start pulses, then one done pulse, then busy=0.
- Loop and stop: seq_len=2, loop_en=1.
  - note_idx sequence is 0,1,0,1, with no done.
  - stop in the middle of entry 1: next cycle busy=0, pitch_maxval=0, done=0.
- Boundaries:
  - start with seq_len=0: busy stays 0.
  - Entry with dur=0: lasts exactly 1 fs_tick.
  - wr_en during PLAY: does not alter the table, checked by replay.
  - Simultaneous start+stop in IDLE: stays IDLE.
- ARTIC_GAP_EN with GAP_SAMPLES=3: between notes, tone_on=0 for exactly 3 fs_ticks before the next note_start. Without the macro, the next note_start follows the final tick by 2 clk.
